gsau_issue_sched: RTL and testbench

- Schedules and shares one systolic-array issue port between NREQ GSAU-style requesters.
- Arbitrates input rows round-robin.
- Makes weight loads atomic WROWS-beat bursts, issued only after all in-flight input rows have drained.
- Tracks outstanding results with a credit counter and a tag FIFO, and routes each sa_out_en result back to its requester with its vdst.

---
 rtl/gsau_issue_sched.sv | 183 ++++++++++++++++++
 tb/tb_gsau_issue_sched.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsau_issue_sched.sv
// Issue scheduler sharing one systolic-array row port between requesters.
// Round-robin input rows, atomic drained weight bursts, tagged result return.
module gsau_issue_sched #(
    parameter int NREQ         = 2,
    parameter int DATA_W       = 512,
    parameter int TAG_W        = 8,
    parameter int WROWS        = 4,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [NREQ-1:0]                   req_valid,
    output logic [NREQ-1:0]                   req_ready,
    input  logic [NREQ-1:0]                   req_weight,
    input  logic [NREQ*DATA_W-1:0]            req_data,
    input  logic [NREQ*TAG_W-1:0]             req_vdst,
    input  logic                              sa_fifo_has_space,
    output logic [DATA_W-1:0]                 sa_array_in,
    output logic                              sa_input_en,
    output logic                              sa_weight_en,
    input  logic                              sa_out_en,
    input  logic [DATA_W-1:0]                 sa_array_output,
    output logic                              rsp_valid,
    output logic [$clog2(NREQ)-1:0]           rsp_id,
    output logic [TAG_W-1:0]                  rsp_vdst,
    output logic [DATA_W-1:0]                 rsp_data,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              err
);

    localparam int IDW = $clog2(NREQ);
    localparam int IW  = $clog2(MAX_INFLIGHT + 1);
    localparam int PW  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int BW  = (WROWS > 1) ? $clog2(WROWS) : 1;
    localparam int EW  = IDW + TAG_W;

    typedef enum logic [1:0] {
        ARB,
        DRAIN,
        WLOAD
    } state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  owner;
    logic [BW-1:0]   beat;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [EW-1:0]   tag_mem [MAX_INFLIGHT];

    logic [IDW-1:0]  sel;
    logic            sel_found;
    logic [IDW-1:0]  acc_id;
    logic            acc;
    logic            push;
    logic            pop;
    logic            credit_ok;
    logic [EW-1:0]   head;

    // Round-robin pick: first valid requester after the pointer, with wrap.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                sel       = IDW'((int'(rr_ptr) + k) % NREQ);
                sel_found = 1'b1;
            end
        end
    end

    // A same-cycle result frees a credit, so a full window can still accept.
    assign credit_ok = (inflight < IW'(MAX_INFLIGHT)) | sa_out_en;

    // Per-requester accept; at most one bit set.
    always_comb begin
        req_ready = '0;
        case (state)
            ARB: begin
                if (sel_found && !req_weight[sel])
                    req_ready[sel] = sa_fifo_has_space & credit_ok;
            end
            WLOAD: begin
                req_ready[owner] = req_valid[owner] & req_weight[owner]
                                 & sa_fifo_has_space;
            end
            default: req_ready = '0;
        endcase
    end

    assign acc    = |(req_valid & req_ready);
    assign acc_id = (state == WLOAD) ? owner : sel;
    assign push   = acc && (state == ARB);
    assign pop    = sa_out_en && (inflight != '0);
    assign head   = tag_mem[rd_ptr];

    // Tag storage; occupancy is tracked by inflight.
    always_ff @(posedge CLK) begin
        if (push)
            tag_mem[wr_ptr] <= {sel, req_vdst[sel*TAG_W +: TAG_W]};
    end

    // Control FSM, credit counter, tag pointers and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ARB;
            rr_ptr       <= IDW'(NREQ - 1);
            owner        <= '0;
            beat         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            inflight     <= '0;
            err          <= 1'b0;
            sa_array_in  <= '0;
            sa_input_en  <= 1'b0;
            sa_weight_en <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_vdst     <= '0;
            rsp_data     <= '0;
        end else begin
            sa_input_en  <= 1'b0;
            sa_weight_en <= 1'b0;
            rsp_valid    <= 1'b0;

            if (acc) begin
                sa_array_in  <= req_data[acc_id*DATA_W +: DATA_W];
                sa_input_en  <= push;
                sa_weight_en <= !push;
            end

            if (push)
                wr_ptr <= (wr_ptr == PW'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr + PW'(1);

            if (pop) begin
                rd_ptr    <= (rd_ptr == PW'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr + PW'(1);
                rsp_valid <= 1'b1;
                rsp_id    <= head[EW-1 -: IDW];
                rsp_vdst  <= head[TAG_W-1:0];
                rsp_data  <= sa_array_output;
            end

            if (sa_out_en && inflight == '0)
                err <= 1'b1;

            if (push && !pop)
                inflight <= inflight + IW'(1);
            else if (pop && !push)
                inflight <= inflight - IW'(1);

            case (state)
                ARB: begin
                    if (sel_found && req_weight[sel]) begin
                        owner <= sel;
                        beat  <= '0;
                        state <= (inflight == '0) ? WLOAD : DRAIN;
                    end else if (push) begin
                        rr_ptr <= sel;
                    end
                end
                DRAIN: begin
                    if (inflight == '0)
                        state <= WLOAD;
                end
                WLOAD: begin
                    if (acc) begin
                        if (beat == BW'(WROWS - 1)) begin
                            beat   <= '0;
                            rr_ptr <= owner;
                            state  <= ARB;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end else if (req_valid[owner] && !req_weight[owner]) begin
                        err <= 1'b1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_gsau_issue_sched.sv
// Directed bench for gsau_issue_sched: issue, round-robin, drain,
// credit limit, backpressure, error and reset behaviour.
module tb_gsau_issue_sched;

    localparam int NREQ   = 2;
    localparam int DATA_W = 512;
    localparam int TAG_W  = 8;
    localparam int WROWS  = 4;
    localparam int MAXI   = 16;

    logic                     CLK = 1'b0;
    logic                     RST;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0]          req_weight;
    logic [NREQ*DATA_W-1:0]   req_data;
    logic [NREQ*TAG_W-1:0]    req_vdst;
    logic                     sa_fifo_has_space;
    logic [DATA_W-1:0]        sa_array_in;
    logic                     sa_input_en;
    logic                     sa_weight_en;
    logic                     sa_out_en;
    logic [DATA_W-1:0]        sa_array_output;
    logic                     rsp_valid;
    logic [0:0]               rsp_id;
    logic [TAG_W-1:0]         rsp_vdst;
    logic [DATA_W-1:0]        rsp_data;
    logic [4:0]               inflight;
    logic                     err;

    gsau_issue_sched #(
        .NREQ(NREQ), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .WROWS(WROWS), .MAX_INFLIGHT(MAXI)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_weight(req_weight), .req_data(req_data),
        .req_vdst(req_vdst),
        .sa_fifo_has_space(sa_fifo_has_space),
        .sa_array_in(sa_array_in), .sa_input_en(sa_input_en),
        .sa_weight_en(sa_weight_en), .sa_out_en(sa_out_en),
        .sa_array_output(sa_array_output),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_vdst(rsp_vdst), .rsp_data(rsp_data),
        .inflight(inflight), .err(err)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] d0, d1, dw, dr;
    int  wcnt;
    logic starve, bad_data;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        req_valid = '0;
        req_weight = '0;
        req_data = '0;
        req_vdst = '0;
        sa_fifo_has_space = 1'b1;
        sa_out_en = 1'b0;
        sa_array_output = '0;
        d0 = {16{32'hC0DE_0001}};
        d1 = {16{32'hB1B1_0002}};
        dw = {16{32'h7E16_0003}};
        dr = {16{32'h5E5B_0004}};
        step();
        step();
        chk("rst_input_en", sa_input_en, 0);
        chk("rst_weight_en", sa_weight_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_err", err, 0);
        chk("rst_array_in", sa_array_in, 0);
        RST = 1'b0;

        // single input row and its result
        req_data = {d1, d0};
        req_vdst = {8'h00, 8'h2A};
        req_valid = 2'b01;
        #1;
        chk("single_ready", req_ready, 2'b01);
        step();
        req_valid = '0;
        chk("single_input_en", sa_input_en, 1);
        chk("single_weight_en", sa_weight_en, 0);
        chk("single_data", sa_array_in, d0);
        chk("single_inflight", inflight, 1);
        step();
        chk("single_strobe_width", sa_input_en, 0);
        chk("single_hold_data", sa_array_in, d0);
        sa_out_en = 1'b1;
        sa_array_output = dr;
        step();
        sa_out_en = 1'b0;
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_id", rsp_id, 0);
        chk("single_rsp_vdst", rsp_vdst, 8'h2A);
        chk("single_rsp_data", rsp_data, dr);
        chk("single_inflight0", inflight, 0);
        step();
        chk("single_rsp_width", rsp_valid, 0);

        // round-robin between two always-valid requesters
        do_reset();
        req_vdst = {8'h11, 8'h10};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", req_ready, (k % 2) ? 2'b10 : 2'b01);
            step();
            chk("rr_data", sa_array_in, (k % 2) ? d1 : d0);
            chk("rr_input_en", sa_input_en, 1);
        end
        req_valid = '0;
        chk("rr_inflight", inflight, 4);
        for (int k = 0; k < 4; k++) begin
            sa_out_en = 1'b1;
            sa_array_output = {16{32'h5000_0000 + k}};
            step();
            chk("rr_rsp_id", rsp_id, k % 2);
            chk("rr_rsp_vdst", rsp_vdst, 8'h10 + k % 2);
            chk("rr_rsp_data", rsp_data, {16{32'h5000_0000 + k}});
        end
        sa_out_en = 1'b0;
        chk("rr_inflight0", inflight, 0);

        // weight load waits for three in-flight rows to drain
        req_valid = 2'b01;
        req_vdst = {8'h00, 8'h30};
        for (int k = 0; k < 3; k++) step();
        chk("drain_inflight3", inflight, 3);
        req_data = {dw, d0};
        req_valid = 2'b10;
        req_weight = 2'b10;
        #1;
        chk("drain_ready_arb", req_ready, 2'b00);
        step();
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            sa_out_en = 1'b1;
            #1;
            chk("drain_ready_hold", req_ready, 2'b00);
            step();
        end
        sa_out_en = 1'b0;
        chk("drain_inflight0", inflight, 0);
        wcnt = 0;
        starve = 1'b0;
        bad_data = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (wcnt == WROWS) break;
            #1;
            if (req_ready[0]) starve = 1'b1;
            step();
            if (sa_input_en) starve = 1'b1;
            if (sa_weight_en) begin
                wcnt++;
                if (sa_array_in !== dw) bad_data = 1'b1;
            end
        end
        chk("drain_wbeats", wcnt, WROWS);
        chk("drain_starve", starve, 0);
        chk("drain_wdata", bad_data, 0);
        #1;
        chk("drain_back_arb", req_ready, 2'b01);
        req_valid = '0;
        req_weight = '0;

        // credit limit with a same-cycle result
        do_reset();
        req_valid = 2'b01;
        for (int k = 0; k < MAXI; k++) begin
            req_vdst = {8'h00, 8'(8'h40 + k)};
            step();
        end
        chk("credit_inflight16", inflight, 16);
        #1;
        chk("credit_ready0", req_ready, 2'b00);
        sa_out_en = 1'b1;
        sa_array_output = dr;
        #1;
        chk("credit_ready_pop", req_ready, 2'b01);
        step();
        sa_out_en = 1'b0;
        req_valid = '0;
        chk("credit_inflight_same", inflight, 16);
        chk("credit_input_en", sa_input_en, 1);
        chk("credit_rsp_valid", rsp_valid, 1);
        chk("credit_rsp_vdst", rsp_vdst, 8'h40);

        // backpressure in the middle of a weight burst
        do_reset();
        req_data = {d1, dw};
        req_valid = 2'b01;
        req_weight = 2'b01;
        wcnt = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (sa_weight_en) wcnt++;
        end
        chk("bp_two_beats", wcnt, 2);
        sa_fifo_has_space = 1'b0;
        #1;
        chk("bp_ready0", req_ready, 2'b00);
        for (int k = 0; k < 3; k++) begin
            step();
            if (sa_weight_en) wcnt++;
        end
        chk("bp_held", wcnt, 2);
        sa_fifo_has_space = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (wcnt == WROWS) break;
            step();
            if (sa_weight_en) wcnt++;
        end
        req_valid = '0;
        req_weight = '0;
        chk("bp_total", wcnt, WROWS);
        step();
        chk("bp_idle", sa_weight_en, 0);

        // result with empty tag FIFO
        do_reset();
        sa_out_en = 1'b1;
        step();
        sa_out_en = 1'b0;
        chk("err_empty", err, 1);
        chk("err_no_rsp", rsp_valid, 0);
        chk("err_inflight", inflight, 0);
        step();
        chk("err_sticky", err, 1);

        // input row from owner during burst, then reset mid-burst
        do_reset();
        chk("rst_err_clear", err, 0);
        req_valid = 2'b01;
        req_weight = 2'b01;
        step();
        step();
        chk("wl_beat1", sa_weight_en, 1);
        req_weight = 2'b00;
        #1;
        chk("wl_bad_ready", req_ready, 2'b00);
        step();
        chk("wl_bad_err", err, 1);
        chk("wl_bad_no_beat", sa_input_en | sa_weight_en, 0);
        req_weight = 2'b01;
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("wlrst_weight_en", sa_weight_en, 0);
        chk("wlrst_input_en", sa_input_en, 0);
        chk("wlrst_array_in", sa_array_in, 0);
        chk("wlrst_err", err, 0);
        chk("wlrst_inflight", inflight, 0);
        #1;
        chk("wlrst_arb", req_ready, 2'b00);
        step();
        #1;
        chk("wlrst_new_burst", req_ready, 2'b01);
        req_valid = '0;
        req_weight = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
